// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 8-bit ALU between two requesters.
// Requester 0 is the issue stage and requester 1 is the auxiliary sequencer.
// Requests are granted round-robin. Operands are held on the ALU inputs for
// EXEC_CYCLES cycles, then the result and flags are captured into a response
// register that stays valid until the consumer accepts it.
//
// Handshake semantics (request and response sides alike): a transfer happens
// on a rising clock edge where valid && ready are both high. The source keeps
// its payload stable while valid is high and ready is low. A source may drop
// valid before a transfer, which withdraws that request. The response side
// holds rsp_valid and the rsp_* payload until rsp_ready is seen.
module alu_arbiter #(
    parameter int W           = 8,
    parameter int EXEC_CYCLES = 1   // legal range 1..15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic [2:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_rslt,
    input  logic         alu_zero,
    input  logic         alu_par,
    input  logic         alu_sco,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_rslt,
    output logic [2:0]   rsp_flags,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The exec counter is loaded with EXEC_CYCLES-1 and the result is
    // captured on the edge where it reads zero.
    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state;
    logic       last_grant;
    logic [3:0] exec_cnt;
    logic       grant;
    logic       accept;

    // Round-robin grant: a sole requester wins, a tie goes to the requester
    // that was not served last.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    // Accept is offered only in IDLE, only to the granted requester, and
    // never while reset is asserted.
    always_comb begin
        req_ready = 2'b00;
        if (reset_n && (state == ST_IDLE)) begin
            if (grant) req_ready[1] = req_valid[1];
            else       req_ready[0] = req_valid[0];
        end
    end

    assign accept    = |(req_valid & req_ready);
    assign dbg_state = state;

    // Main FSM: latch the op on accept, hold it during EXEC, capture the
    // result, then hold the response until the consumer takes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            exec_cnt   <= 4'd0;
            alu_op     <= 3'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_rslt   <= '0;
            rsp_flags  <= 3'd0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_op     <= grant ? req1_op : req0_op;
                        alu_a      <= grant ? req1_a  : req0_a;
                        alu_b      <= grant ? req1_b  : req0_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        exec_cnt   <= CNT_INIT;
                        busy       <= 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_cnt != 4'd0) begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end else begin
                        rsp_rslt  <= alu_rslt;
                        rsp_flags <= {alu_zero, alu_par, alu_sco};
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
